// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the CPU fetch front end
// Purpose: fetch FSM state enum, datapath widths, prefetch FIFO entry layout
//          and a word-alignment helper used by the fetch unit.
// Ports:   none (package).
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc_plus4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush
// Purpose: stores fetched entries; head is presented straight from storage.
// Ports:   clk_i/rst_i (async active-low), push_i + push_data_i, pop_i,
//          flush_i (clears contents, beats push/pop), head_o, count_o.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign w_push  = push_i && !flush_i;
    assign w_pop   = pop_i && !flush_i && (r_count != '0);
    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end ahead of IF/ID
// Purpose: owns the fetch PC, runs the req/ack handshake to instruction
//          memory, buffers {pc+4, instr} in a prefetch FIFO and applies
//          branch/jump redirects (flush + drop of in-flight response).
// Ports:   clk_i, rst_i (async active-low);
//          imem_req_o/imem_addr_o/imem_ack_i/imem_data_i memory handshake;
//          redirect_i/redirect_pc_i from MEM stage; stall_i from IF/ID;
//          instr_valid_o/instr_o/pc_plus4_o FIFO head; fifo_count_o occupancy.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       imem_req_o,
    output logic [XLEN-1:0]            imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [INSTR_W-1:0]         imem_data_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    input  logic                       stall_i,
    output logic                       instr_valid_o,
    output logic [INSTR_W-1:0]         instr_o,
    output logic [XLEN-1:0]            pc_plus4_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_held_addr;

    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_redirect_pc = word_align(redirect_pc_i);

    // In IDLE a new request is only offered when the FIFO has room (judged on
    // the registered count) and no redirect is arriving. rst_i is folded in so
    // the request reads 0 while reset is held. Once a request is pending it is
    // held with its address until ack, whatever redirect_i does.
    always_comb begin
        imem_req_o  = 1'b1;
        imem_addr_o = r_held_addr;
        if (r_state == IDLE) begin
            imem_req_o  = rst_i && (fifo_count_o < CW'(DEPTH)) && !redirect_i;
            imem_addr_o = r_fetch_pc;
        end
    end

    assign w_fire = imem_req_o && imem_ack_i;
    // DROP responses and any response landing in a redirect cycle are discarded.
    assign w_push = w_fire && !redirect_i && (r_state != DROP);
    assign w_pop  = instr_valid_o && !stall_i && !redirect_i;

    assign w_push_entry.pc_plus4 = imem_addr_o + 32'd4;
    assign w_push_entry.instr    = imem_data_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_held_addr <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                    end else if (imem_req_o) begin
                        r_held_addr <= r_fetch_pc;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (imem_ack_i) begin
                        r_state <= IDLE;
                        if (!redirect_i) begin
                            r_fetch_pc <= r_held_addr + 32'd4;
                        end
                    end else if (redirect_i) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // A redirect overrides any PC update made above.
            if (redirect_i) begin
                r_fetch_pc <= w_redirect_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (redirect_i),
        .head_o      (w_head),
        .count_o     (fifo_count_o)
    );

    assign instr_valid_o = (fifo_count_o != '0);
    assign instr_o       = w_head.instr;
    assign pc_plus4_o    = w_head.pc_plus4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk, rst_n;
    logic        req, ack, redirect, stall, valid;
    logic [31:0] addr, data, redirect_pc, instr, pc4;
    logic [2:0]  fcount;

    if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_data_i   (data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .instr_valid_o (valid),
        .instr_o       (instr),
        .pc_plus4_o    (pc4),
        .fifo_count_o  (fcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model
    logic [31:0] salt;
    int  lat_min, lat_max, mem_wait, mem_lat;
    bit  mem_active;
    // reference model: expected FIFO contents and next fetch address
    logic [63:0] q[$];
    logic [31:0] m_pc, m_paddr;
    bit          m_pend, m_pdisc;
    // last step observations
    logic        obs_req, obs_ack;
    logic [31:0] obs_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ salt;
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; ack = 1'b0;
        redirect_pc = '0; data = '0;
        q.delete(); m_pc = 32'h0; m_pend = 0; m_pdisc = 0; mem_active = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, answer memory, check against the model,
    // then advance the model to what the next edge should produce.
    task automatic step(input bit rd, input logic [31:0] tgt, input bit st);
        logic exp_req;
        bit   disc;
        @(negedge clk);
        redirect = rd; redirect_pc = tgt; stall = st;
        #1;
        if (req) begin
            if (!mem_active) begin
                mem_active = 1; mem_wait = 0;
                mem_lat = $urandom_range(lat_max, lat_min);
            end
            ack  = (mem_wait >= mem_lat);
            data = ack ? mem_word(addr) : $urandom;
        end else begin
            ack = 1'b0; data = $urandom;
        end
        #1;
        n_cmp++;
        if (valid !== (q.size() != 0)) begin
            n_bad++; $display("FAIL valid: got %b want %b", valid, q.size() != 0);
        end
        n_cmp++;
        if (fcount !== 3'(q.size())) begin
            n_bad++; $display("FAIL count: got %0d want %0d", fcount, q.size());
        end
        exp_req = m_pend ? 1'b1 : (!rd && q.size() < DEPTH);
        n_cmp++;
        if (req !== exp_req) begin
            n_bad++; $display("FAIL req: got %b want %b", req, exp_req);
        end
        if (req === 1'b1) begin
            n_cmp++;
            if (addr !== (m_pend ? m_paddr : m_pc)) begin
                n_bad++; $display("FAIL addr: got %h want %h", addr, m_pend ? m_paddr : m_pc);
            end
        end
        if (valid === 1'b1 && !st && !rd && q.size() > 0) begin
            n_cmp++;
            if ({pc4, instr} !== q[0]) begin
                n_bad++; $display("FAIL head: got %h want %h", {pc4, instr}, q[0]);
            end
            void'(q.pop_front());
        end
        if (rd) begin
            q.delete();
            m_pc = tgt & ~32'h3;
        end
        disc = (m_pend && m_pdisc) || rd;
        if (req === 1'b1 && ack) begin
            if (!disc) begin
                q.push_back({addr + 32'd4, data});
                m_pc = addr + 32'd4;
            end
            m_pend = 0; mem_active = 0;
        end else if (req === 1'b1) begin
            if (!m_pend) m_paddr = addr;
            m_pend = 1; m_pdisc = disc; mem_wait++;
        end
        obs_req = req; obs_addr = addr; obs_ack = ack;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; ack = 1'b0;
        redirect_pc = '0; data = '0;
        #2;
        n_cmp++; if (req !== 1'b0)   begin n_bad++; $display("FAIL rst_req: got %b want 0", req); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr); end
        n_cmp++; if (pc4 !== 32'h0)  begin n_bad++; $display("FAIL rst_pc4: got %h want 0", pc4); end
        n_cmp++; if (fcount !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", fcount); end
        reset_dut();
    endtask

    task automatic test_zero_wait();
        reset_dut(); lat_min = 0; lat_max = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0);
            n_cmp++;
            if (obs_addr !== 32'(4 * k) || obs_ack !== 1'b1) begin
                n_bad++; $display("FAIL zw_addr%0d: got %h ack %b want %h ack 1", k, obs_addr, obs_ack, 4 * k);
            end
            n_cmp++;
            if (fcount > 3'd1) begin n_bad++; $display("FAIL zw_count%0d: got %0d want <=1", k, fcount); end
            if (k > 0) begin
                n_cmp++;
                if (pc4 !== 32'(4 * k)) begin n_bad++; $display("FAIL zw_pc4_%0d: got %h want %h", k, pc4, 4 * k); end
            end
        end
    endtask

    task automatic test_stall_full();
        int fires;
        reset_dut(); lat_min = 0; lat_max = 0; fires = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 1);
            if (obs_req && obs_ack) fires++;
        end
        n_cmp++; if (fires != DEPTH) begin n_bad++; $display("FAIL full_fires: got %0d want %0d", fires, DEPTH); end
        n_cmp++; if (obs_req !== 1'b0 || fcount !== 3'd4) begin
            n_bad++; $display("FAIL full_hold: got req %b count %0d want req 0 count 4", obs_req, fcount);
        end
        step(0, 0, 0);
        n_cmp++; if (obs_req !== 1'b0) begin n_bad++; $display("FAIL full_release: got req %b want 0", obs_req); end
        step(0, 0, 1);
        n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h10) begin
            n_bad++; $display("FAIL full_resume: got req %b addr %h want req 1 addr 10", obs_req, obs_addr);
        end
    endtask

    task automatic test_latency();
        reset_dut(); lat_min = 2; lat_max = 2;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1);
            n_cmp++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h0 || obs_ack !== (k == 2) || fcount !== 3'd0) begin
                n_bad++; $display("FAIL lat_cyc%0d: got req %b addr %h ack %b count %0d", k, obs_req, obs_addr, obs_ack, fcount);
            end
        end
        step(0, 0, 1);
        n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h4 || fcount !== 3'd1) begin
            n_bad++; $display("FAIL lat_next: got req %b addr %h count %0d want 1 4 1", obs_req, obs_addr, fcount);
        end
    endtask

    task automatic test_redirect_busy();
        reset_dut(); lat_min = 0; lat_max = 0;
        step(0, 0, 1); step(0, 0, 1);
        lat_min = 3; lat_max = 3;
        step(0, 0, 1);
        step(1, 32'h40, 1);
        n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h8) begin
            n_bad++; $display("FAIL rb_hold: got req %b addr %h want 1 8", obs_req, obs_addr);
        end
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 1);
            n_cmp++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h8 || obs_ack !== (k == 1) || fcount !== 3'd0) begin
                n_bad++; $display("FAIL rb_wait%0d: got req %b addr %h ack %b count %0d", k, obs_req, obs_addr, obs_ack, fcount);
            end
        end
        lat_min = 0; lat_max = 0;
        step(0, 0, 1);
        n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h40 || fcount !== 3'd0) begin
            n_bad++; $display("FAIL rb_target: got req %b addr %h count %0d want 1 40 0", obs_req, obs_addr, fcount);
        end
    endtask

    task automatic test_redirect_flush();
        reset_dut(); lat_min = 0; lat_max = 0;
        repeat (3) step(0, 0, 1);
        step(1, 32'h43, 0);
        n_cmp++; if (fcount !== 3'd3 || valid !== 1'b1 || obs_req !== 1'b0) begin
            n_bad++; $display("FAIL rf_cycle: got count %0d valid %b req %b want 3 1 0", fcount, valid, obs_req);
        end
        step(0, 0, 1);
        n_cmp++; if (valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h40) begin
            n_bad++; $display("FAIL rf_after: got valid %b req %b addr %h want 0 1 40", valid, obs_req, obs_addr);
        end
    endtask

    task automatic test_wrap();
        reset_dut(); lat_min = 0; lat_max = 0;
        step(1, 32'hFFFF_FFF9, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        n_cmp++; if (obs_addr !== 32'h0 || pc4 !== 32'hFFFF_FFFC) begin
            n_bad++; $display("FAIL wrap: got addr %h head %h want 0 fffffffc", obs_addr, pc4);
        end
        repeat (4) step(0, 0, 0);
    endtask

    task automatic test_reset_mid_busy();
        reset_dut(); lat_min = 0; lat_max = 0;
        step(0, 0, 1); step(0, 0, 1);
        lat_min = 5; lat_max = 5;
        step(0, 0, 1);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (req !== 1'b0 || valid !== 1'b0 || fcount !== 3'd0 || instr !== 32'h0 || pc4 !== 32'h0) begin
            n_bad++; $display("FAIL mid_reset: got req %b valid %b count %0d instr %h pc4 %h", req, valid, fcount, instr, pc4);
        end
        reset_dut(); lat_min = 0; lat_max = 0;
        step(0, 0, 0);
        n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            n_bad++; $display("FAIL mid_restart: got req %b addr %h want 1 0", obs_req, obs_addr);
        end
    endtask

    task automatic test_random();
        reset_dut(); lat_min = 0; lat_max = 3;
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 99) < 8, $urandom, $urandom_range(0, 99) < 35);
        end
    endtask

    initial begin
        salt = $urandom;
        lat_min = 0; lat_max = 0;
        test_reset();
        test_zero_wait();
        test_stall_full();
        test_latency();
        test_redirect_busy();
        test_redirect_flush();
        test_wrap();
        test_reset_mid_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch front end for the 5-stage pipelined CPU. It sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word fetches to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions, each with its PC+4, in a small prefetch FIFO.
- Hands them to IF/ID under a stall signal.
- Branch/jump redirects from the MEM stage flush the FIFO and discard any in-flight response.

Parameters:
- DEPTH, 4, prefetch FIFO entries. Power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk_i, in, 1, clock. Rising edge.
- rst_i, in, 1, reset. Asynchronous, active-low.
- imem_req_o, out, 1, fetch request.
- imem_addr_o, out, 32, fetch word address. Bits [1:0] always 0.
- imem_ack_i, in, 1, memory completes the transaction in the cycle where req && ack.
- imem_data_i, in, 32, instruction word. Valid when ack is high.
- redirect_i, in, 1, taken branch/jump (PCSrc from MEM stage).
- redirect_pc_i, in, 32, target address. Bits [1:0] ignored and treated as 0.
- stall_i, in, 1, IF/ID not accepting (hazard stall).
- instr_valid_o, out, 1, FIFO head valid.
- instr_o, out, 32, FIFO head instruction.
- pc_plus4_o, out, 32, FIFO head PC+4.
- fifo_count_o, out, $clog2(DEPTH+1), current occupancy.

Behaviour:
Reset (asynchronous, rst_i=0):
- State IDLE, FIFO empty, count=0.
- fetch_pc=RESET_PC, held address = RESET_PC.
- imem_req_o=0, instr_valid_o=0, instr_o=0, pc_plus4_o=0.

FSM states:
- IDLE: no transaction pending.
- BUSY: request pending, response will be kept.
- DROP: request pending, response will be discarded.

Request generation:
- IDLE: imem_req_o = (count<DEPTH) && !redirect_i. imem_addr_o = fetch_pc.
- BUSY and DROP: imem_req_o=1. imem_addr_o = held address.
- The count<DEPTH test uses the registered count, before any same-cycle pop.

Transitions:
- IDLE, req && ack: push {fetch_pc+4, imem_data_i}; fetch_pc += 4; stay IDLE. This gives one instruction per cycle with zero-wait memory.
- IDLE, req && !ack: latch held address = fetch_pc; go BUSY.
- BUSY, ack && !redirect_i: push {held+4, data}; fetch_pc = held+4; go IDLE.
- BUSY, redirect_i && !ack: go DROP.
- BUSY, redirect_i && ack: discard data; go IDLE.
- DROP, ack: discard data; go IDLE.
- Redirect in any state: fetch_pc = {redirect_pc_i[31:2], 2'b00}.
- Handshake rule: once imem_req_o is raised, req and addr stay constant until ack. A redirect never withdraws a pending request.

FIFO:
- Output: instr_valid_o = (count!=0). instr_o and pc_plus4_o come from the head registers. There is no combinational path from any input to these outputs.
- Pop: instr_valid_o && !stall_i && !redirect_i.
- Push and pop in the same cycle: count is unchanged. This is legal even at count==DEPTH, because no push can occur when a request was issued at count==DEPTH.
- redirect_i has priority: in that cycle, count becomes 0 from the next cycle. The same-cycle push and pop are both suppressed. Read/write pointers reset to 0.
- In the redirect cycle the head is still presented. The downstream flush logic squashes it.
- Pointers wrap modulo DEPTH.

Arithmetic:
- PC math is 32-bit, wrap-around modulo 2^32. 32'hFFFF_FFFC + 4 = 0.

Reset mid-operation:
- Returns to IDLE immediately and loses the pending transaction.
- The instruction memory must share the same reset.

Decomposition:
- Shared package (cpu_pkg):
  - Fetch state enum {IDLE, BUSY, DROP}.
  - XLEN=32 and INSTR_W=32 constants.
  - Fetch-entry struct {pc_plus4, instr}.
- One natural sub-module: fetch_fifo, a synchronous FIFO with push, pop, flush, count and head outputs.
  - Parameterised by DEPTH and WIDTH (64 here).
  - Same clk_i/rst_i.
- FSM, PC and request logic stay in the top.

Test Plan:
1. Zero-wait memory (ack tied to req), stall_i=0, after reset → addresses 0,4,8,12 in consecutive cycles. Instructions appear on instr_o in order with pc_plus4_o = 4,8,12,16; fifo_count_o ≤1.
2. stall_i=1 held → exactly DEPTH=4 fetches (addr 0..12). imem_req_o then stays 0, count=4. Releasing stall resumes at addr 16.
3. Memory with 3-cycle ack latency → req and addr 0 stay stable for 3 cycles. One push on the ack cycle; next req at addr 4 is in the same cycle as that push.
4. redirect_i with redirect_pc_i=32'h40 while in BUSY at addr 8, ack two cycles later → req stays at 8 until ack, and the data is discarded (count stays 0). Next request is at 32'h40.
5. redirect_i with FIFO holding 3 entries and stall_i=0 → no pop that cycle. Next cycle count=0, instr_valid_o=0. Next fetch at the redirect target; redirect_pc_i=32'h43 fetches 32'h40.
6. rst_i asserted mid-BUSY → outputs return immediately (asynchronously) to reset values. After release, the first request is at RESET_PC.
